// File: rtl/aes_vector_sequencer.sv
// Start-triggered AES test-vector source: ROM sweep, fixed-key/LFSR plaintext,
// or KeySbox key sweep, presented over a valid/ready handshake.
module aes_vector_sequencer #(
  parameter int           KEY_SIZE    = 128,
  parameter int           NUM_VECTORS = 21,
  parameter logic [127:0] LFSR_SEED   = 128'h1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [15:0]         vec_count,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [127:0]        plain_text,
  output logic [KEY_SIZE-1:0] cypher_key,
  output logic [15:0]         vec_idx,
  output logic                busy,
  output logic                done
);
  localparam int               PTR_W     = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_VECTORS - 1);
  localparam logic [127:0]     SEED      = (LFSR_SEED == 128'h0) ? 128'h1 : LFSR_SEED;
  localparam logic [127:0]     LFSR_TAPS = {8'he1, 120'h0};
  localparam logic [1:0]       M_LFSR    = 2'd1;

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_DONE} state_t;

  // Entries 0 and 1 are the reference keys; the rest are a golden-ratio fill.
  // Every ROM plaintext is zero, so plaintext is only non-zero in LFSR mode.
  function automatic logic [KEY_SIZE-1:0] rom_key(input logic [PTR_W-1:0] idx);
    logic [KEY_SIZE-1:0] k;
    logic [31:0]         w;
    w = 32'(idx) * 32'h9e3779b9;
    if (idx == PTR_W'(0)) begin
      k = KEY_SIZE'(128'h10a58869d74be5a374cf867cfb473859);
    end else if (idx == PTR_W'(1)) begin
      k = KEY_SIZE'(128'hcaea65cdbb75e9169ecd22ebe6e54675);
    end else begin
      k = '0;
      for (int i = 0; i < KEY_SIZE / 32; i++) k[i*32 +: 32] = (i < 4) ? w : ~w;
    end
    return k;
  endfunction

  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 128'h0);
  endfunction

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [15:0]           n_q, n_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [127:0]          lfsr_q, lfsr_d;
  logic                  out_valid_q, out_valid_d;
  logic [127:0]          plain_text_q, plain_text_d;
  logic [KEY_SIZE-1:0]   cypher_key_q, cypher_key_d;
  logic [15:0]           vec_idx_q, vec_idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  xfer, last_vec, load;
  logic [PTR_W-1:0]      ptr_nxt, load_ptr;
  logic [127:0]          lfsr_nxt, load_lfsr;
  logic [1:0]            load_mode;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    n_d          = n_q;
    ptr_d        = ptr_q;
    lfsr_d       = lfsr_q;
    out_valid_d  = out_valid_q;
    plain_text_d = plain_text_q;
    cypher_key_d = cypher_key_q;
    vec_idx_d    = vec_idx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    ptr_nxt      = (ptr_q == PTR_LAST) ? PTR_W'(0) : ptr_q + 1'b1;
    lfsr_nxt     = lfsr_step(lfsr_q);
    xfer         = out_valid_q && out_ready;
    last_vec     = (vec_idx_q == n_q - 16'd1);
    load         = 1'b0;
    load_ptr     = ptr_q;
    load_lfsr    = lfsr_q;
    load_mode    = mode_q;

    // abort overrides everything, including a simultaneous start or last transfer
    if (abort) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            load_mode   = (mode == 2'd3) ? 2'd0 : mode;
            mode_d      = load_mode;
            n_d         = (vec_count == 16'd0) ? 16'(NUM_VECTORS) : vec_count;
            ptr_d       = '0;
            lfsr_d      = SEED;
            vec_idx_d   = '0;
            load        = 1'b1;
            load_ptr    = '0;
            load_lfsr   = SEED;
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
            state_d     = S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (xfer) begin
            if (mode_q == M_LFSR) lfsr_d = lfsr_nxt;
            if (last_vec) begin
              state_d     = S_DONE;
              out_valid_d = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
            end else begin
              ptr_d     = ptr_nxt;
              vec_idx_d = vec_idx_q + 16'd1;
              load      = 1'b1;
              load_ptr  = ptr_nxt;
              load_lfsr = lfsr_nxt;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    if (load) begin
      cypher_key_d = rom_key((load_mode == M_LFSR) ? PTR_W'(0) : load_ptr);
      plain_text_d = (load_mode == M_LFSR) ? load_lfsr : 128'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mode_q       <= 2'd0;
      n_q          <= 16'(NUM_VECTORS);
      ptr_q        <= '0;
      lfsr_q       <= SEED;
      out_valid_q  <= 1'b0;
      plain_text_q <= '0;
      cypher_key_q <= '0;
      vec_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      n_q          <= n_d;
      ptr_q        <= ptr_d;
      lfsr_q       <= lfsr_d;
      out_valid_q  <= out_valid_d;
      plain_text_q <= plain_text_d;
      cypher_key_q <= cypher_key_d;
      vec_idx_q    <= vec_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign plain_text = plain_text_q;
  assign cypher_key = cypher_key_q;
  assign vec_idx    = vec_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_aes_vector_sequencer.sv
// Self-checking bench for aes_vector_sequencer: a run-level model builds the
// expected vector list at each start and a negedge process checks every cycle.
module tb_aes_vector_sequencer;
  localparam int KS = 128;
  localparam int NV = 21;
  localparam logic [127:0] KEY0 = 128'h10a58869d74be5a374cf867cfb473859;
  localparam logic [127:0] KEY1 = 128'hcaea65cdbb75e9169ecd22ebe6e54675;

  logic           clk = 1'b0;
  logic           reset, start, abort, out_ready;
  logic [1:0]     mode;
  logic [15:0]    vec_count;
  logic           out_valid, busy, done;
  logic [127:0]   plain_text;
  logic [KS-1:0]  cypher_key;
  logic [15:0]    vec_idx;

  always #5 clk = ~clk;

  aes_vector_sequencer #(.KEY_SIZE(KS), .NUM_VECTORS(NV), .LFSR_SEED(128'h1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .vec_count(vec_count), .out_ready(out_ready), .out_valid(out_valid),
    .plain_text(plain_text), .cypher_key(cypher_key), .vec_idx(vec_idx),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  function automatic logic [127:0] rom_key_m(input int i);
    logic [31:0] w;
    if (i == 0) return KEY0;
    if (i == 1) return KEY1;
    w = 32'(i) * 32'h9e3779b9;
    return {4{w}};
  endfunction

  function automatic logic [127:0] lfsr_m(input logic [127:0] s);
    return s[0] ? ((s >> 1) ^ {8'he1, 120'h0}) : (s >> 1);
  endfunction

  // Expected vectors of the current run
  logic [127:0] exp_plain[64];
  logic [127:0] exp_key[64];
  int           exp_n;

  task automatic build(input logic [1:0] md, input logic [15:0] vc);
    logic [1:0]   m;
    logic [127:0] l;
    m = (md == 2'd3) ? 2'd0 : md;
    exp_n = (vc == 16'd0) ? NV : int'(vc);
    l = 128'h1;
    for (int k = 0; k < exp_n && k < 64; k++) begin
      exp_key[k]   = (m == 2'd1) ? rom_key_m(0) : rom_key_m(k % NV);
      exp_plain[k] = (m == 2'd1) ? l : 128'h0;
      l = lfsr_m(l);
    end
  endtask

  bit           m_active = 0, m_done = 0;
  int           m_pos = 0;
  int           busy_cnt = 0, done_cnt = 0, acc_cnt = 0;
  logic [127:0] obs_key[32];
  logic [127:0] obs_plain[32];

  always @(negedge clk) begin
    bit nd;
    if (reset) begin
      m_active = 0;
      m_done   = 0;
      m_pos    = 0;
    end else begin
      chk("out_valid", out_valid, m_active);
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      if (m_active && out_valid) begin
        chk("plain_text", plain_text, exp_plain[m_pos]);
        chk("cypher_key", cypher_key, exp_key[m_pos]);
        chk("vec_idx", vec_idx, m_pos);
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      nd = 0;
      if (abort) begin
        m_active = 0;
      end else if (m_active && out_ready) begin
        if (m_pos < 32) begin
          obs_key[m_pos]   = cypher_key;
          obs_plain[m_pos] = plain_text;
        end
        acc_cnt++;
        if (m_pos == exp_n - 1) begin
          m_active = 0;
          nd = 1;
        end else begin
          m_pos++;
        end
      end else if (!m_active && !m_done && start) begin
        build(mode, vec_count);
        m_active = 1;
        m_pos = 0;
      end
      m_done = nd;
    end
  end

  // Pulse start, then scramble mode/vec_count to confirm they were latched.
  task automatic start_run(input logic [1:0] md, input logic [15:0] vc);
    mode = md;
    vec_count = vc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = (md == 2'd1) ? 2'd2 : 2'd1;
    vec_count = 16'd7;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int c = 0;
    while ((m_active || m_done || busy) && c < max_cycles) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= max_cycles) timeout_fail(name);
  endtask

  initial begin
    int c;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    mode = 2'd0; vec_count = 16'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_plain", plain_text, 0);
    chk("rst_key", cypher_key, 0);
    chk("rst_vec_idx", vec_idx, 0);

    // Full ROM sweep at full throughput
    busy_cnt = 0; done_cnt = 0; acc_cnt = 0;
    out_ready = 1'b1;
    start_run(2'd0, 16'd0);
    wait_idle("t1_run", 100);
    chk("t1_busy_cycles", busy_cnt, 21);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_key0", obs_key[0], KEY0);
    chk("t1_key1", obs_key[1], KEY1);
    chk("t1_plain20", obs_plain[20], 0);

    // ROM wrap
    done_cnt = 0; acc_cnt = 0;
    start_run(2'd0, 16'd25);
    wait_idle("t2_run", 100);
    chk("t2_accepted", acc_cnt, 25);
    chk("t2_wrap_key21", obs_key[21], KEY0);
    chk("t2_wrap_key22", obs_key[22], KEY1);
    chk("t2_done_pulses", done_cnt, 1);

    // Fixed key, LFSR plaintext
    start_run(2'd1, 16'd3);
    wait_idle("t3_run", 50);
    chk("t3_pt0", obs_plain[0], 128'h1);
    chk("t3_pt1", obs_plain[1], 128'he1000000000000000000000000000000);
    chk("t3_pt2", obs_plain[2], 128'h70800000000000000000000000000000);
    chk("t3_key2", obs_key[2], KEY0);
    chk("t3_model_pt2", exp_plain[2], 128'h70800000000000000000000000000000);

    // KeySbox sweep under random backpressure
    acc_cnt = 0;
    out_ready = 1'b0;
    start_run(2'd2, 16'd30);
    c = 0;
    while ((m_active || m_done) && c < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      c++;
    end
    if (c >= 1000) timeout_fail("t4_run");
    chk("t4_accepted", acc_cnt, 30);
    chk("t4_key23", obs_key[23], rom_key_m(2));

    // Abort while stalled at vec_idx 5
    done_cnt = 0;
    out_ready = 1'b1;
    start_run(2'd0, 16'd0);
    c = 0;
    while (vec_idx != 16'd5 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 50) timeout_fail("t5_reach_idx5");
    out_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("t5_stall_idx", vec_idx, 5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_abort_valid", out_valid, 0);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_holds_idx", vec_idx, 5);
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_no_done", done_cnt, 0);
    out_ready = 1'b1;
    start_run(2'd0, 16'd3);
    chk("t5_restart_idx", vec_idx, 0);
    chk("t5_restart_key", cypher_key, KEY0);
    wait_idle("t5_run", 50);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("t6_start_abort_valid", out_valid, 0);
    chk("t6_start_abort_busy", busy, 0);

    // start during busy is ignored
    acc_cnt = 0; done_cnt = 0;
    start_run(2'd0, 16'd6);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("t7_run", 50);
    chk("t7_accepted", acc_cnt, 6);
    chk("t7_done_pulses", done_cnt, 1);

    // Asynchronous reset mid-run
    start_run(2'd1, 16'd10);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("t8_rst_out_valid", out_valid, 0);
    chk("t8_rst_busy", busy, 0);
    chk("t8_rst_done", done, 0);
    chk("t8_rst_plain", plain_text, 0);
    chk("t8_rst_key", cypher_key, 0);
    chk("t8_rst_vec_idx", vec_idx, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/aes_vector_sequencer.md
# aes_vector_sequencer

Parametrised test-vector source for the AES core and the side-channel capture flow. It replaces the fixed-depth, free-running plaintext/key generator with a start-triggered sequencer that has a valid/ready output handshake, selectable key width, programmable vector count, and three generation modes. The three modes are ROM sweep, fixed-key/LFSR-plaintext for trace collection, and KeySbox key sweep. It sits between the capture controller and the AES input register.

## Interface
- KEY_SIZE, 128, cypher key width; legal values are 128, 192 and 256.
- NUM_VECTORS, 21, number of ROM entries, 1..256.
- LFSR_SEED, 128'h1, plaintext LFSR seed; a seed of 0 is replaced by 1.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- abort  in  1  terminates the run; takes effect in the same cycle it is sampled.
- mode  in  2  0 = ROM sweep, 1 = fixed key with LFSR plaintext, 2 = KeySbox sweep (plaintext all-zero, ROM keys), 3 = reserved and treated as 0.
- vec_count  in  16  number of vectors to emit; 0 means NUM_VECTORS.
- out_ready  in  1  consumer accepts the vector.
- out_valid  out  1  a vector is presented.
- plain_text  out  128  plaintext.
- cypher_key  out  KEY_SIZE  key.
- vec_idx  out  16  ordinal of the presented vector within the run, starting at 0.
- busy  out  1  high from start acceptance until the run ends.
- done  out  1  one-cycle pulse when the last vector is accepted.

## Operation
- ROM: NUM_VECTORS entries, each holding a 128-bit plaintext and a 256-bit key. cypher_key is the low KEY_SIZE bits of the key entry.
  - Entry 0: plaintext 0, key low 128 bits 128'h10a58869d74be5a374cf867cfb473859.
  - Entry 1: plaintext 0, key low 128 bits 128'hcaea65cdbb75e9169ecd22ebe6e54675.
- ROM pointer advances on each accepted transfer and wraps from NUM_VECTORS-1 to 0.
- LFSR: 128-bit Galois, polynomial x^128+x^7+x^2+x+1, shifting toward the LSB. Loaded with the seed on each start and advanced once per accepted transfer in mode 1 only.
- Mode 0: plaintext and key come from ROM[ptr].
- Mode 1: key is ROM[0] key for the whole run; plaintext is the current LFSR state.
- Mode 2: plaintext is 0; key is ROM[ptr] key.
- mode and vec_count are latched at start. Changes to them during a run are ignored.
- FSM states:
  - IDLE: start moves to PRESENT.
  - PRESENT: out_valid=1. A transfer (out_valid & out_ready) with vec_idx == N-1 moves to DONE. Any other transfer loads the next vector and stays in PRESENT.
  - DONE: lasts one cycle, done=1, then returns to IDLE.
  - abort in any state returns to IDLE. It clears out_valid and busy and does not pulse done.
- Output stability: while out_valid=1 and out_ready=0, plain_text, cypher_key and vec_idx hold.
- start while busy is ignored. start and abort asserted together in IDLE: abort wins and the FSM stays in IDLE.

## Timing
- Reset values: out_valid=0, busy=0, done=0, plain_text=0, cypher_key=0, vec_idx=0, ptr=0, LFSR=seed, FSM in IDLE.
- start sampled at edge t: out_valid, busy and vector 0 are registered at t+1.
- Throughput is full: with out_ready held high, one vector per cycle and no bubbles.
- Last transfer at edge t: out_valid=0 and done=1 at t+1; busy=0 at t+1.
- done is low at t+2.
- A new start is accepted from t+2.
- abort at edge t: out_valid=0 and busy=0 at t+1.
- Outputs keep their last values after the run ends; only out_valid qualifies them.
- vec_idx counts modulo 2^16 and never exceeds N-1.

## Test plan
- Mode 0, vec_count=0, out_ready=1: 21 consecutive vectors.
  - Key 0 = 128'h10a58869d74be5a374cf867cfb473859, key 1 = 128'hcaea65cdbb75e9169ecd22ebe6e54675, all plaintexts 0.
  - done pulses one cycle after vec_idx=20; busy is high for exactly 21 cycles.
- Mode 0, vec_count=25: entry 0 is presented again at vec_idx=21 (wrap); done follows vec_idx=24.
- Mode 1, seed 1, vec_count=3:
  - Key is ROM[0] key on all three vectors.
  - Plaintexts are 128'h1, then 128'he1000000000000000000000000000000, then 128'h70800000000000000000000000000000.
- Backpressure: mode 2, out_ready toggled in a pseudo-random pattern.
  - Outputs are stable while stalled.
  - No vector is skipped or duplicated.
  - Plaintext is always 0.
- abort asserted at vec_idx=5 while stalled: out_valid=0 the next cycle, no done pulse. A following start resumes at vec_idx=0 with ROM[0].
- Reset asserted mid-run, asynchronously: every output is immediately at its reset value. start pulsed during busy is ignored, and the run length is unchanged.
